// File: rtl/imm_encode_pipe_pkg.sv
// Shared definitions for the immediate encoder pipeline.
//   imm_src_e   : immediate format selector (none / I / SB / JL)
//   MASK_*      : instruction bits owned by each format's immediate field
//   sign_run_ok : true when imm[15:lsb] are all equal, i.e. the value fits
//                 in an (lsb+1)-bit two's complement field
package imm_encode_pipe_pkg;

    typedef enum logic [1:0] {
        IMM_NONE = 2'b00,
        IMM_I    = 2'b01,
        IMM_SB   = 2'b10,
        IMM_JL   = 2'b11
    } imm_src_e;

    localparam logic [15:0] MASK_NONE = 16'h0000;
    localparam logic [15:0] MASK_I    = 16'hF800;
    localparam logic [15:0] MASK_SB   = 16'hC038;
    localparam logic [15:0] MASK_JL   = 16'hFFC0;

    function automatic logic sign_run_ok(input logic [15:0] imm, input int unsigned lsb);
        logic [15:0] upper;
        upper = 16'hFFFF << lsb;
        return ((imm & upper) == upper) || ((imm & upper) == 16'h0000);
    endfunction

endpackage

// File: rtl/imm_field_pack.sv
// Combinational immediate scatter/merge.
//   Base    : instruction word, bits outside the field mask are preserved
//   Imm     : signed 16-bit immediate
//   ImmSrc  : format selector (imm_src_e encoding)
//   Instr   : merged word, or Base untouched when the immediate does not fit
//   Imm_Err : immediate out of range for the selected format
module imm_field_pack
    import imm_encode_pipe_pkg::*;
(
    input  logic [15:0] Base,
    input  logic [15:0] Imm,
    input  logic [1:0]  ImmSrc,
    output logic [15:0] Instr,
    output logic        Imm_Err
);

    logic [15:0] mask;
    logic [15:0] placed;
    logic        legal;

    always_comb begin
        mask   = MASK_NONE;
        placed = '0;
        legal  = 1'b0;
        case (imm_src_e'(ImmSrc))
            IMM_NONE: begin
                mask  = MASK_NONE;
                legal = (Imm == '0);
            end
            IMM_I: begin
                mask   = MASK_I;
                placed = {Imm[4:0], 11'd0};
                legal  = sign_run_ok(Imm, 4);
            end
            IMM_SB: begin
                mask   = MASK_SB;
                placed = {Imm[4:3], 8'd0, Imm[2:0], 3'd0};
                legal  = sign_run_ok(Imm, 4);
            end
            IMM_JL: begin
                // Instr[15] carries the sign; the extender replicates it over i[15:9]
                mask   = MASK_JL;
                placed = {Imm[15], Imm[3:0], Imm[8:4], 6'd0};
                legal  = sign_run_ok(Imm, 9);
            end
            default: begin
                mask   = MASK_NONE;
                placed = '0;
                legal  = 1'b0;
            end
        endcase

        Instr   = legal ? ((Base & ~mask) | placed) : Base;
        Imm_Err = ~legal;
    end

endmodule

// File: rtl/imm_encode_pipe.sv
// Two-stage valid/ready immediate encoder.
//   clk, rst_n          : clock, asynchronous active-low reset
//   In_Valid/In_Ready   : input handshake for Base/Imm/ImmSrc
//   Out_Valid/Out_Ready : output handshake for Instr/Imm_Err
//   Err_Sticky          : set by any accepted error word
//   Err_Count           : saturating count of accepted error words
//   Err_Clr             : synchronous clear of Err_Sticky/Err_Count (wins)
// Stage 1 registers the raw inputs, imm_field_pack computes between stages,
// stage 2 registers the result. Each stage refills in the cycle it drains.
module imm_encode_pipe
    import imm_encode_pipe_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             In_Valid,
    output logic             In_Ready,
    input  logic [15:0]      Base,
    input  logic [15:0]      Imm,
    input  logic [1:0]       ImmSrc,
    output logic             Out_Valid,
    input  logic             Out_Ready,
    output logic [15:0]      Instr,
    output logic             Imm_Err,
    output logic             Err_Sticky,
    output logic [CNT_W-1:0] Err_Count,
    input  logic             Err_Clr
);

    logic        s1_valid;
    logic [15:0] s1_base;
    logic [15:0] s1_imm;
    logic [1:0]  s1_src;

    logic        s2_valid;
    logic [15:0] s2_instr;
    logic        s2_err;

    logic [15:0] pack_instr;
    logic        pack_err;

    logic s2_adv;
    logic s1_take;
    logic s1_move;
    logic err_take;

    // Stage 2 can load when empty or when its word leaves this cycle; this
    // makes In_Ready combinational from Out_Ready so a full pipe never bubbles.
    assign s2_adv   = !s2_valid || Out_Ready;
    assign In_Ready = !s1_valid || s2_adv;
    assign s1_take  = In_Valid && In_Ready;
    assign s1_move  = s1_valid && s2_adv;
    assign err_take = s2_valid && Out_Ready && s2_err;

    imm_field_pack u_pack (
        .Base    (s1_base),
        .Imm     (s1_imm),
        .ImmSrc  (s1_src),
        .Instr   (pack_instr),
        .Imm_Err (pack_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_base  <= '0;
            s1_imm   <= '0;
            s1_src   <= '0;
        end else begin
            if (In_Ready) begin
                s1_valid <= In_Valid;
            end
            if (s1_take) begin
                s1_base <= Base;
                s1_imm  <= Imm;
                s1_src  <= ImmSrc;
            end
        end
    end

    // Data only loads alongside a valid word, so a stalled output holds steady.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_instr <= '0;
            s2_err   <= 1'b0;
        end else begin
            if (s2_adv) begin
                s2_valid <= s1_valid;
            end
            if (s1_move) begin
                s2_instr <= pack_instr;
                s2_err   <= pack_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Err_Sticky <= 1'b0;
            Err_Count  <= '0;
        end else if (Err_Clr) begin
            Err_Sticky <= 1'b0;
            Err_Count  <= '0;
        end else if (err_take) begin
            Err_Sticky <= 1'b1;
            if (Err_Count != '1) begin
                Err_Count <= Err_Count + CNT_W'(1);
            end
        end
    end

    assign Out_Valid = s2_valid;
    assign Instr     = s2_instr;
    assign Imm_Err   = s2_err;

endmodule

// File: tb/tb_imm_encode_pipe.sv
// Self-checking bench for imm_encode_pipe: directed steps in one initial
// block, expected words queued at input handshake and checked at output.
module tb_imm_encode_pipe;

    localparam int CNT_W = 2;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             In_Valid = 1'b0;
    logic             In_Ready;
    logic [15:0]      Base = '0;
    logic [15:0]      Imm = '0;
    logic [1:0]       ImmSrc = '0;
    logic             Out_Valid;
    logic             Out_Ready = 1'b0;
    logic [15:0]      Instr;
    logic             Imm_Err;
    logic             Err_Sticky;
    logic [CNT_W-1:0] Err_Count;
    logic             Err_Clr = 1'b0;

    always #5 clk = ~clk;

    imm_encode_pipe #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .In_Valid   (In_Valid),
        .In_Ready   (In_Ready),
        .Base       (Base),
        .Imm        (Imm),
        .ImmSrc     (ImmSrc),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .Instr      (Instr),
        .Imm_Err    (Imm_Err),
        .Err_Sticky (Err_Sticky),
        .Err_Count  (Err_Count),
        .Err_Clr    (Err_Clr)
    );

    typedef struct {
        logic [15:0] base;
        logic [15:0] imm;
        logic [1:0]  src;
        logic [15:0] instr;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Reference model, written from the field tables.
    function automatic logic [15:0] tb_mask(input logic [1:0] s);
        case (s)
            2'b01:   return 16'hF800;
            2'b10:   return 16'hC038;
            2'b11:   return 16'hFFC0;
            default: return 16'h0000;
        endcase
    endfunction

    function automatic logic tb_legal(input logic [15:0] i, input logic [1:0] s);
        int v;
        v = $signed(i);
        case (s)
            2'b00:   return v == 0;
            2'b11:   return (v >= -512) && (v <= 511);
            default: return (v >= -16) && (v <= 15);
        endcase
    endfunction

    function automatic logic [15:0] tb_place(input logic [15:0] i, input logic [1:0] s);
        logic [15:0] p;
        p = '0;
        case (s)
            2'b01: p[15:11] = i[4:0];
            2'b10: begin p[15:14] = i[4:3]; p[5:3] = i[2:0]; end
            2'b11: begin p[15] = i[15]; p[14:11] = i[3:0]; p[10:6] = i[8:4]; end
            default: p = '0;
        endcase
        return p;
    endfunction

    // Datapath-side immediate extension (inverse of the encoder).
    function automatic logic [15:0] tb_ext(input logic [15:0] w, input logic [1:0] s);
        case (s)
            2'b01:   return {{11{w[15]}}, w[15:11]};
            2'b10:   return {{11{w[15]}}, w[15:14], w[5:3]};
            2'b11:   return {{7{w[15]}}, w[10:6], w[14:11]};
            default: return 16'h0000;
        endcase
    endfunction

    task automatic push_exp(input logic [15:0] b, input logic [15:0] i, input logic [1:0] s,
                            input logic [15:0] xi, input logic xe);
        exp_t e;
        e.base = b; e.imm = i; e.src = s; e.instr = xi; e.err = xe;
        sb.push_back(e);
    endtask

    task automatic push_m(input logic [15:0] b, input logic [15:0] i, input logic [1:0] s);
        if (tb_legal(i, s))
            push_exp(b, i, s, (b & ~tb_mask(s)) | tb_place(i, s), 1'b0);
        else
            push_exp(b, i, s, b, 1'b1);
    endtask

    // Present one word, wait (bounded) for acceptance; returns 1 after the handshake edge.
    task automatic send(input logic [15:0] b, input logic [15:0] i, input logic [1:0] s,
                        input logic [15:0] xi, input logic xe);
        int n;
        n = 0;
        Base = b; Imm = i; ImmSrc = s; In_Valid = 1'b1;
        @(negedge clk);
        while (!In_Ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!In_Ready) begin
            chk("send_timeout", {15'b0, In_Ready}, 16'h0001);
        end else begin
            @(posedge clk);
            push_exp(b, i, s, xi, xe);
        end
        #1 In_Valid = 1'b0;
    endtask

    task automatic send_m(input logic [15:0] b, input logic [15:0] i, input logic [1:0] s);
        if (tb_legal(i, s))
            send(b, i, s, (b & ~tb_mask(s)) | tb_place(i, s), 1'b0);
        else
            send(b, i, s, b, 1'b1);
    endtask

    // Output-side scoreboard: a handshake completes at the following rising edge.
    always @(negedge clk) begin
        if (rst_n && Out_Valid && Out_Ready) begin
            if (sb.size() == 0) begin
                chk("sb_unexpected_out", {15'b0, Out_Valid}, 16'h0000);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("instr", Instr, e.instr);
                chk("imm_err", {15'b0, Imm_Err}, {15'b0, e.err});
                if (!e.err) begin
                    chk("roundtrip", tb_ext(Instr, e.src), e.imm);
                    chk("outside_mask", Instr & ~tb_mask(e.src), e.base & ~tb_mask(e.src));
                end
            end
        end
    end

    initial begin
        logic [15:0] bb [4];
        logic [15:0] ii [4];
        logic [1:0]  ss [4];
        logic [15:0] held;
        logic        acc;
        int          idx;
        int          n;

        // Reset state
        #2;
        chk("rst_out_valid", {15'b0, Out_Valid}, 16'h0000);
        chk("rst_instr", Instr, 16'h0000);
        chk("rst_imm_err", {15'b0, Imm_Err}, 16'h0000);
        chk("rst_sticky", {15'b0, Err_Sticky}, 16'h0000);
        chk("rst_count", 16'(Err_Count), 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rel_in_ready", {15'b0, In_Ready}, 16'h0001);
        Out_Ready = 1'b1;

        // I-type with latency check
        send(16'h0123, 16'hFFFD, 2'b01, 16'hE923, 1'b0);
        @(negedge clk);
        chk("lat_c1_valid", {15'b0, Out_Valid}, 16'h0000);
        @(negedge clk);
        chk("lat_c2_valid", {15'b0, Out_Valid}, 16'h0001);
        chk("lat_c2_instr", Instr, 16'hE923);
        @(posedge clk);
        #1;

        // SB, JL, none (legal)
        send(16'h1234, 16'h0005, 2'b10, 16'h122C, 1'b0);
        send(16'h003F, 16'hFF38, 2'b11, 16'hC4FF, 1'b0);
        send(16'h5A5A, 16'h0000, 2'b00, 16'h5A5A, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        chk("no_err_sticky", {15'b0, Err_Sticky}, 16'h0000);

        // Range error
        send(16'h0123, 16'h0010, 2'b01, 16'h0123, 1'b1);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("err_sticky", {15'b0, Err_Sticky}, 16'h0001);
        chk("err_count1", 16'(Err_Count), 16'h0001);

        // Clear coincident with a counted error
        send(16'h0123, 16'hFFE0, 2'b01, 16'h0123, 1'b1);
        @(posedge clk);
        #1 Err_Clr = 1'b1;
        @(posedge clk);
        #1 Err_Clr = 1'b0;
        chk("clr_wins_count", 16'(Err_Count), 16'h0000);
        chk("clr_wins_sticky", {15'b0, Err_Sticky}, 16'h0000);

        // Saturation: four errors into a 2-bit counter
        send(16'h5A5A, 16'h0001, 2'b00, 16'h5A5A, 1'b1);
        send(16'h0000, 16'h0200, 2'b11, 16'h0000, 1'b1);
        send(16'hFFFF, 16'hFDFF, 2'b11, 16'hFFFF, 1'b1);
        send(16'h0000, 16'h8000, 2'b10, 16'h0000, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("sat_count", 16'(Err_Count), 16'h0003);
        chk("sat_sticky", {15'b0, Err_Sticky}, 16'h0001);
        Err_Clr = 1'b1;
        @(posedge clk);
        #1 Err_Clr = 1'b0;
        chk("clr_count", 16'(Err_Count), 16'h0000);

        // Backpressure: stream 4 words with Out_Ready low
        bb[0] = 16'h1111; ii[0] = 16'h0007; ss[0] = 2'b01;
        bb[1] = 16'h2222; ii[1] = 16'hFFF1; ss[1] = 2'b10;
        bb[2] = 16'h3333; ii[2] = 16'h01FF; ss[2] = 2'b11;
        bb[3] = 16'h4444; ii[3] = 16'hFE00; ss[3] = 2'b11;
        Out_Ready = 1'b0;
        idx = 0;
        Base = bb[0]; Imm = ii[0]; ImmSrc = ss[0]; In_Valid = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            acc = In_Ready;
            @(posedge clk);
            if (acc) begin
                push_m(bb[idx], ii[idx], ss[idx]);
                idx++;
            end
            #1;
            if (idx < 4) begin
                Base = bb[idx]; Imm = ii[idx]; ImmSrc = ss[idx];
            end
        end
        chk("bp_accepted", 16'(idx), 16'h0002);
        chk("bp_in_ready", {15'b0, In_Ready}, 16'h0000);
        chk("bp_out_valid", {15'b0, Out_Valid}, 16'h0001);
        chk("bp_head", Instr, (bb[0] & ~tb_mask(ss[0])) | tb_place(ii[0], ss[0]));
        held = Instr;
        repeat (3) begin
            @(negedge clk);
            chk("bp_stable", Instr, held);
        end
        @(posedge clk);
        #1 Out_Ready = 1'b1;
        #1;
        chk("no_bubble_in_ready", {15'b0, In_Ready}, 16'h0001);
        n = 0;
        while (idx < 4 && n < 10) begin
            n++;
            @(negedge clk);
            acc = In_Ready;
            @(posedge clk);
            if (acc) begin
                push_m(bb[idx], ii[idx], ss[idx]);
                idx++;
            end
            #1;
            if (idx < 4) begin
                Base = bb[idx]; Imm = ii[idx]; ImmSrc = ss[idx];
            end
        end
        In_Valid = 1'b0;
        chk("bp_all_accepted", 16'(idx), 16'h0004);
        repeat (4) @(posedge clk);
        #1;

        // Round trip: random legal immediates, then some arbitrary ones
        for (int k = 0; k < 30; k++) begin
            logic [1:0]  s;
            logic [15:0] i;
            s = 2'($urandom_range(0, 3));
            case (s)
                2'b00:   i = 16'h0000;
                2'b11:   i = 16'($urandom_range(0, 1023)) - 16'd512;
                default: i = 16'($urandom_range(0, 31)) - 16'd16;
            endcase
            send_m(16'($urandom), i, s);
        end
        for (int k = 0; k < 6; k++) begin
            send_m(16'($urandom), 16'($urandom), 2'($urandom_range(0, 3)));
        end
        repeat (4) @(posedge clk);
        #1;

        // Asynchronous reset with both stages full
        Out_Ready = 1'b0;
        send_m(16'hABCD, 16'h0003, 2'b01);
        send_m(16'hBCDE, 16'h0004, 2'b10);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", {15'b0, Out_Valid}, 16'h0000);
        chk("arst_instr", Instr, 16'h0000);
        chk("arst_imm_err", {15'b0, Imm_Err}, 16'h0000);
        sb.delete();
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("arst_rel_in_ready", {15'b0, In_Ready}, 16'h0001);
        chk("arst_still_empty", {15'b0, Out_Valid}, 16'h0000);
        Out_Ready = 1'b1;
        send_m(16'h0F0F, 16'hFFF0, 2'b01);
        @(negedge clk);
        chk("arst_lat_c1", {15'b0, Out_Valid}, 16'h0000);
        @(negedge clk);
        chk("arst_lat_c2", {15'b0, Out_Valid}, 16'h0001);

        n = 0;
        while (sb.size() != 0 && n < 20) begin
            n++;
            @(posedge clk);
        end
        #1;
        chk("sb_drained", 16'(sb.size()), 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
